id_stage_q: RTL

Parametrised decode stage with a `QDEPTH`-entry instruction queue between fetch and decode, and a registered ID→EX pipeline register. It decodes the LoongArch-32 subset the core already supports, plus `blt`/`bge`/`bltu`/`bgeu`. Branches are resolved at issue; a taken branch flushes every younger queued instruction. It replaces the single-slot decode stage: fetch can run ahead of decode stalls, and EX timing is decoupled from register-file reads.

---
 rtl/id_stage_q.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_q.sv
// id_stage_q: decode stage for the LoongArch-32 subset with a QDEPTH-entry
// instruction queue in front of decode and a registered ID->EX payload.
// Conditional branches, b, bl and jirl are resolved when they issue; a taken
// branch discards every younger queued instruction.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   if_to_id_valid/pc/inst   fetch push into the queue
//   o_id_ready               queue has a free entry this cycle
//   rf_raddr1/2, rf_rdata1/2 register-file reads for the head instruction
//   idu_nready_go            hazard unit holds the head instruction
//   ex_flush                 clears the queue and the EX register
//   br_taken/br_target       head branch issues taken, redirect PC
//   br_stall                 head is a register-dependent branch on hold
//   i_ex_ready               EX accepts the EX register contents
//   id_to_ex_*               registered instruction handed to EX
module id_stage_q #(
  parameter int QDEPTH   = 4,
  parameter int ALU_OP_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_to_id_valid,
  input  logic [31:0]         if_to_id_pc,
  input  logic [31:0]         if_to_id_inst,
  output logic                o_id_ready,
  output logic [4:0]          rf_raddr1,
  output logic [4:0]          rf_raddr2,
  input  logic [31:0]         rf_rdata1,
  input  logic [31:0]         rf_rdata2,
  input  logic                idu_nready_go,
  input  logic                ex_flush,
  output logic                br_taken,
  output logic [31:0]         br_target,
  output logic                br_stall,
  input  logic                i_ex_ready,
  output logic                id_to_ex_valid,
  output logic [31:0]         id_to_ex_pc,
  output logic [31:0]         id_to_ex_inst,
  output logic [31:0]         id_to_ex_src1,
  output logic [31:0]         id_to_ex_src2,
  output logic [ALU_OP_W-1:0] id_to_ex_alu_op,
  output logic [4:0]          id_to_ex_rf_waddr
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(QDEPTH);

  logic [31:0]   pc_mem   [QDEPTH];
  logic [31:0]   inst_mem [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;

  logic        head_valid, issue, enq;
  logic [31:0] pc, inst;

  assign head_valid = (count != '0);
  assign o_id_ready = (count < DEPTH_CNT);
  assign issue = head_valid & ~idu_nready_go & (~id_to_ex_valid | i_ex_ready) & ~ex_flush;
  assign enq   = if_to_id_valid & o_id_ready & ~br_taken & ~ex_flush;

  // The head is forced to zero when empty so every decode output idles at 0.
  assign pc   = head_valid ? pc_mem[rd_ptr]   : 32'd0;
  assign inst = head_valid ? inst_mem[rd_ptr] : 32'd0;

  logic [4:0] rd, rj, rk;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  logic i_add, i_sub, i_slt, i_sltu, i_nor, i_and, i_or, i_xor, i_sll, i_srl, i_sra;
  logic i_mul, i_mulh, i_mulhu, i_div, i_mod, i_divu, i_modu;
  logic i_slli, i_srli, i_srai, i_slti, i_sltui, i_addi, i_andi, i_ori, i_xori;
  logic i_ld, i_st, i_lu12i, i_pcaddu, i_jirl, i_b, i_bl;
  logic i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu;

  assign i_add    = inst[31:15] == 17'h00020;
  assign i_sub    = inst[31:15] == 17'h00022;
  assign i_slt    = inst[31:15] == 17'h00024;
  assign i_sltu   = inst[31:15] == 17'h00025;
  assign i_nor    = inst[31:15] == 17'h00028;
  assign i_and    = inst[31:15] == 17'h00029;
  assign i_or     = inst[31:15] == 17'h0002a;
  assign i_xor    = inst[31:15] == 17'h0002b;
  assign i_sll    = inst[31:15] == 17'h0002e;
  assign i_srl    = inst[31:15] == 17'h0002f;
  assign i_sra    = inst[31:15] == 17'h00030;
  assign i_mul    = inst[31:15] == 17'h00038;
  assign i_mulh   = inst[31:15] == 17'h00039;
  assign i_mulhu  = inst[31:15] == 17'h0003a;
  assign i_div    = inst[31:15] == 17'h00040;
  assign i_mod    = inst[31:15] == 17'h00041;
  assign i_divu   = inst[31:15] == 17'h00042;
  assign i_modu   = inst[31:15] == 17'h00043;
  assign i_slli   = inst[31:15] == 17'h00081;
  assign i_srli   = inst[31:15] == 17'h00089;
  assign i_srai   = inst[31:15] == 17'h00091;
  assign i_slti   = inst[31:22] == 10'h008;
  assign i_sltui  = inst[31:22] == 10'h009;
  assign i_addi   = inst[31:22] == 10'h00a;
  assign i_andi   = inst[31:22] == 10'h00d;
  assign i_ori    = inst[31:22] == 10'h00e;
  assign i_xori   = inst[31:22] == 10'h00f;
  assign i_ld     = inst[31:22] == 10'h0a2;
  assign i_st     = inst[31:22] == 10'h0a6;
  assign i_lu12i  = inst[31:25] == 7'h0a;
  assign i_pcaddu = inst[31:25] == 7'h0e;
  assign i_jirl   = inst[31:26] == 6'h13;
  assign i_b      = inst[31:26] == 6'h14;
  assign i_bl     = inst[31:26] == 6'h15;
  assign i_beq    = inst[31:26] == 6'h16;
  assign i_bne    = inst[31:26] == 6'h17;
  assign i_blt    = inst[31:26] == 6'h18;
  assign i_bge    = inst[31:26] == 6'h19;
  assign i_bltu   = inst[31:26] == 6'h1a;
  assign i_bgeu   = inst[31:26] == 6'h1b;

  logic is_cbr, shift_imm, logic_imm, no_rk, use_imm, use_pc, gr_we;
  assign is_cbr    = i_beq | i_bne | i_blt | i_bge | i_bltu | i_bgeu;
  assign shift_imm = i_slli | i_srli | i_srai;
  assign logic_imm = i_andi | i_ori | i_xori;
  // Forms with no second register operand read address 0 on port 2.
  assign no_rk   = shift_imm | logic_imm | i_slti | i_sltui | i_addi | i_ld |
                   i_lu12i | i_pcaddu | i_jirl | i_b | i_bl;
  assign use_imm = no_rk | i_st;
  assign use_pc  = i_jirl | i_bl | i_pcaddu;

  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_cbr | i_st) ? rd : (no_rk ? 5'd0 : rk);

  logic [31:0] imm, src1, src2;
  logic [4:0]  dest;
  always_comb begin
    imm = {{20{inst[21]}}, inst[21:10]};
    if (shift_imm)               imm = {27'd0, inst[14:10]};
    else if (logic_imm)          imm = {20'd0, inst[21:10]};
    else if (i_lu12i | i_pcaddu) imm = {inst[24:5], 12'd0};
    else if (i_jirl | i_bl)      imm = 32'd4;
  end
  assign src1 = use_pc ? pc : rf_rdata1;
  assign src2 = use_imm ? imm : rf_rdata2;
  assign dest = i_bl ? 5'd1 : rd;
  assign gr_we = (dest != 5'd0) & ~i_st & ~is_cbr & ~i_b;

  logic [21:0] alu_op;
  assign alu_op = {i_modu, i_mod, i_divu, i_div, i_mulhu, i_mulh, i_mul, i_ld,
                   gr_we, i_st, i_lu12i, i_sra | i_srai, i_srl | i_srli,
                   i_sll | i_slli, i_xor | i_xori, i_or | i_ori, i_nor,
                   i_and | i_andi, i_sltu | i_sltui, i_slt | i_slti, i_sub,
                   i_add | i_addi | i_ld | i_st | i_jirl | i_bl | i_pcaddu};

  logic eq, lt, ltu, br_cond;
  assign eq  = rf_rdata1 == rf_rdata2;
  assign lt  = $signed(rf_rdata1) < $signed(rf_rdata2);
  assign ltu = rf_rdata1 < rf_rdata2;
  assign br_cond = i_b | i_bl | i_jirl | (i_beq & eq) | (i_bne & ~eq) |
                   (i_blt & lt) | (i_bge & ~lt) | (i_bltu & ltu) | (i_bgeu & ~ltu);
  assign br_taken = issue & br_cond;
  assign br_stall = head_valid & idu_nready_go & (is_cbr | i_jirl);

  always_comb begin
    br_target = pc + {{14{inst[25]}}, inst[25:10], 2'b00};
    if (i_b | i_bl)  br_target = pc + {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    else if (i_jirl) br_target = rf_rdata1 + {{14{inst[25]}}, inst[25:10], 2'b00};
  end

  // Queue storage carries no reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= if_to_id_pc;
      inst_mem[wr_ptr] <= if_to_id_inst;
    end
  end

  // A taken branch empties the queue; the branch itself has already been
  // captured into the EX register this same cycle.
  always_ff @(posedge clk) begin
    if (rst || ex_flush || br_taken) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, issue};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_to_ex_valid    <= 1'b0;
      id_to_ex_pc       <= '0;
      id_to_ex_inst     <= '0;
      id_to_ex_src1     <= '0;
      id_to_ex_src2     <= '0;
      id_to_ex_alu_op   <= '0;
      id_to_ex_rf_waddr <= '0;
    end else if (ex_flush) begin
      id_to_ex_valid <= 1'b0;
    end else if (issue) begin
      id_to_ex_valid    <= 1'b1;
      id_to_ex_pc       <= pc;
      id_to_ex_inst     <= inst;
      id_to_ex_src1     <= src1;
      id_to_ex_src2     <= src2;
      id_to_ex_alu_op   <= ALU_OP_W'(alu_op);
      id_to_ex_rf_waddr <= dest;
    end else if (i_ex_ready) begin
      id_to_ex_valid <= 1'b0;
    end
  end

endmodule
